// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
// uart_tx_sched
//   Two-requester UART transmitter (8N1, LSB first, idle high). Requesters
//   present a byte on reqN_dat with reqN_stb held high until reqN_ack. When
//   the line is idle the scheduler grants one requester round-robin, latches
//   its byte and sends it as one frame. The bit rate comes from a phase
//   accumulator: each cycle INC is added modulo 2^ACC_W, and the carry-out is
//   the bit tick. Bit rate = Fclk * INC / 2^ACC_W.
//
// Parameters
//   ACC_W  phase accumulator width in bits
//   INC    phase increment per clock
//
// Ports
//   clk_100M   system clock, rising edge
//   rst        asynchronous active-high reset
//   req0_dat   byte from requester 0, stable while req0_stb=1
//   req0_stb   requester 0 has a byte pending
//   req0_ack   one-cycle pulse, requester 0 byte accepted
//   req1_dat   byte from requester 1, stable while req1_stb=1
//   req1_stb   requester 1 has a byte pending
//   req1_ack   one-cycle pulse, requester 1 byte accepted
//   txd        serial output, registered
//   busy       high while a frame is being transmitted
//   grant      index of the most recently granted requester
module uart_tx_sched #(
    parameter int ACC_W = 24,
    parameter int INC   = 154619
) (
    input  logic       clk_100M,
    input  logic       rst,
    input  logic [7:0] req0_dat,
    input  logic       req0_stb,
    output logic       req0_ack,
    input  logic [7:0] req1_dat,
    input  logic       req1_stb,
    output logic       req1_ack,
    output logic       txd,
    output logic       busy,
    output logic       grant
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [ACC_W:0] INC_EXT = (ACC_W + 1)'(INC);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic             tick;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             any_req;
    logic             winner;

    // One extra bit on the add exposes the carry-out, which is the bit tick.
    assign acc_sum = {1'b0, acc} + INC_EXT;
    assign tick    = acc_sum[ACC_W];
    assign any_req = req0_stb | req1_stb;

    // Round-robin pick: a lone requester wins outright; when both are
    // pending, the one that was not granted last time goes next.
    always_comb begin
        winner = 1'b0;
        if (req0_stb && req1_stb) begin
            winner = ~grant;
        end else if (req1_stb) begin
            winner = 1'b1;
        end
    end

    // Frame sequencer. txd is changed one cycle ahead of the state it
    // belongs to, so the line always comes straight from a flop. The
    // accumulator is zeroed on the grant so the first tick of every frame
    // lands a full bit period after the start bit begins.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            grant    <= 1'b1;
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
        end else begin
            acc      <= acc_sum[ACC_W-1:0];
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                    if (any_req) begin
                        acc      <= '0;
                        grant    <= winner;
                        shift    <= winner ? req1_dat : req0_dat;
                        req0_ack <= ~winner;
                        req1_ack <= winner;
                        bit_cnt  <= '0;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        txd   <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter ACC_W, default 24, meaning phase-accumulator width in bits.
REQ-002 SHALL have parameter INC, default 154619, meaning phase increment per clock; bit rate = Fclk*INC/2^ACC_W (921601 Hz at 100 MHz).
REQ-003 SHALL have port clk_100M  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req0_dat  input  8  byte from requester 0; held stable while req0_stb=1.
REQ-006 SHALL have port req0_stb  input  1  requester 0 has a byte pending; held until req0_ack.
REQ-007 SHALL have port req0_ack  output  1  one-cycle pulse: requester 0 byte accepted.
REQ-008 SHALL have ports req1_dat, req1_stb and req1_ack, identical to REQ-005..007 for requester 1.
REQ-009 SHALL have port txd  output  1  serial line, 8N1, LSB first, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is being transmitted.
REQ-011 SHALL have port grant  output  1  index of the requester most recently granted.

Function
REQ-012 SHALL contain an ACC_W-bit phase accumulator adding INC each cycle, modulo 2^ACC_W; tick = carry-out of that add, a single cycle.
REQ-013 SHALL clear the accumulator to 0 in the grant cycle, so every frame starts phase-aligned.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: txd=1 and busy=0; if any stb=1, SHALL grant exactly one requester and go to START in the next cycle.
REQ-016 Arbitration SHALL be round-robin: a single pending requester wins; if both are pending, the requester != grant wins.
REQ-017 In the grant cycle the block SHALL latch the winner's dat into a shift register, update grant, and pulse the winner's ack for exactly one cycle.
REQ-018 START SHALL drive txd=0 and go to DATA on the first tick.
REQ-019 DATA SHALL drive txd = shift[0], shift right on each tick, count 8 ticks with a 3-bit counter, then go to STOP.
REQ-020 STOP SHALL drive txd=1 and go to IDLE on the next tick.
REQ-021 busy SHALL be 1 in START, DATA and STOP.
REQ-022 Frame length from grant to return to IDLE SHALL be 10 ticks: 1085 or 1086 clocks at the default parameters.
REQ-023 A new grant SHALL be possible in the first IDLE cycle after STOP, giving back-to-back frames with no extra idle gap.
REQ-024 A stb asserted during a frame SHALL wait with no ack; it SHALL be considered only in IDLE.
REQ-025 Only the granted requester SHALL receive ack; the other ack SHALL stay 0.
REQ-026 txd SHALL be driven from a register (glitch-free).

Reset
REQ-027 On rst=1, regardless of the clock, the block SHALL set state=IDLE, txd=1, busy=0, req0_ack=0, req1_ack=0, accumulator=0, shift=0, bit counter=0 and grant=1, so that requester 0 wins first.
REQ-028 Reset asserted mid-frame SHALL abort the frame with txd=1 immediately; the aborted byte SHALL NOT be retransmitted.
REQ-029 After rst deasserts, the block SHALL accept requests from the first clock edge.

Verification
REQ-030 After reset, req0_stb=1 with dat=0x55 -> req0_ack pulses one cycle, then txd = 0,1,0,1,0,1,0,1,0,1, each bit 108-109 clocks, then busy=0.
REQ-031 After reset, req0_stb and req1_stb both rise in the same cycle (dat 0xA5 and 0x3C) -> 0xA5 is sent first (grant=0), then 0x3C (grant=1) back-to-back; each ack fires once.
REQ-032 req0 is kept continuously pending with new bytes while req1 has one byte pending -> frame order req0, req1, req0, req0; no requester is starved.
REQ-033 rst pulsed during DATA of byte 0xFF -> txd=1 and busy=0 asynchronously; no further ack; a new request is served normally.
REQ-034 req1_stb rises mid-frame of a req0 byte -> no req1_ack until req0's STOP ends; req1's frame starts in the next cycle.
REQ-035 With parameter INC=2^(ACC_W-3) -> exactly 8 clocks per bit and 80 clocks per frame.
